// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants, types and helpers for the input_debounce block.
// Build option: define INPUT_DEBOUNCE_TOGGLE_EN to add per-channel toggle outputs.
package debounce_pkg;

    // Prescaler and per-channel stability counter widths
    localparam int DEB_PCNT_W = 16;
    localparam int DEB_SCNT_W = 4;

    typedef logic [DEB_PCNT_W-1:0] pcnt_t;
    typedef logic [DEB_SCNT_W-1:0] scnt_t;

    // 10 kHz clock / 100 = 100 Hz sample tick; three stable ticks to accept a change
    localparam pcnt_t DEB_TICK_DIV_DEFAULT     = 16'd100;
    localparam scnt_t DEB_STABLE_TICKS_DEFAULT = 4'd3;

    // Event produced by a channel on the cycle its debounced level changes
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_t;

    // True on the last prescaler count before wrapping
    function automatic logic pcnt_last(input pcnt_t pcnt, input pcnt_t tick_div);
        return pcnt == (tick_div - pcnt_t'(1));
    endfunction

    // True when the current tick completes qualification of a changed input
    function automatic logic scnt_last(input scnt_t scnt, input scnt_t stable_ticks);
        return scnt == (stable_ticks - scnt_t'(1));
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one debounced input channel.
// Two-flop synchroniser, tick-paced stability counter, debounced level and
// one-cycle rise/fall pulses. With INPUT_DEBOUNCE_TOGGLE_EN defined, also a
// toggle bit that inverts on every rise event.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter scnt_t STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
`ifdef INPUT_DEBOUNCE_TOGGLE_EN
    ,
    output logic toggle
`endif
);

    logic  s1;
    logic  s2;
    scnt_t scnt;
    logic  mismatch;
    edge_t evt_next;

    // Synchroniser keeps sampling even while the block is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    assign mismatch = s2 ^ dout;

    // Decide whether this cycle commits a new level, and in which direction
    always_comb begin
        evt_next = EDGE_NONE;
        if (ena && mismatch && tick && scnt_last(scnt, STABLE_TICKS)) begin
            evt_next = s2 ? EDGE_RISE : EDGE_FALL;
        end
    end

    // Stability counter and debounced level; any agreement restarts qualification
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
            dout <= 1'b0;
        end else if (ena) begin
            if (!mismatch) begin
                scnt <= '0;
            end else if (tick) begin
                if (evt_next != EDGE_NONE) begin
                    dout <= s2;
                    scnt <= '0;
                end else begin
                    scnt <= scnt + scnt_t'(1);
                end
            end
        end
    end

    // Event pulses are registered alongside dout so they line up with the level change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= (evt_next == EDGE_RISE);
            fall <= (evt_next == EDGE_FALL);
        end
    end

`ifdef INPUT_DEBOUNCE_TOGGLE_EN
    // Push-button on/off state: flips on every accepted press, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle <= 1'b0;
        end else if (evt_next == EDGE_RISE) begin
            toggle <= ~toggle;
        end
    end
`else
    // No toggle state in this build; the channel provides level and pulses only.
`endif

endmodule

// File: rtl/input_debounce.sv
// input_debounce: conditions raw switch inputs for the display/counter core.
// A shared prescaler produces a one-cycle sample tick every TICK_DIV clocks;
// each of the WIDTH channels is debounced independently against that tick.
// Build option: INPUT_DEBOUNCE_TOGGLE_EN adds the toggle[WIDTH] output.
// Legal parameter ranges: TICK_DIV 2..65535, STABLE_TICKS 1..15.
module input_debounce
    import debounce_pkg::*;
#(
    parameter int    WIDTH        = 8,
    parameter pcnt_t TICK_DIV     = DEB_TICK_DIV_DEFAULT,
    parameter scnt_t STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
`ifdef INPUT_DEBOUNCE_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] toggle
`endif
);

    pcnt_t pcnt;

    // Prescaler: counts 0..TICK_DIV-1 while enabled, tick is high the cycle after the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (ena) begin
            if (pcnt_last(pcnt, TICK_DIV)) begin
                pcnt <= '0;
                tick <= 1'b1;
            end else begin
                pcnt <= pcnt + pcnt_t'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // One independent debounce channel per input bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .ena    (ena),
            .tick   (tick),
            .din    (din[i]),
            .dout   (dout[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
`ifdef INPUT_DEBOUNCE_TOGGLE_EN
            ,
            .toggle (toggle[i])
`endif
        );
    end

endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed bench for input_debounce with TICK_DIV=4, STABLE_TICKS=3.
// Expected events ({rise, fall, dout}) are queued when stimulus is driven and
// compared when the DUT emits a rise/fall pulse.
module tb_input_debounce;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         tick;
`ifdef INPUT_DEBOUNCE_TOGGLE_EN
    logic [W-1:0] toggle;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3*W-1:0] exp_q[$];

    input_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (16'd4),
        .STABLE_TICKS (4'd3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .din    (din),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .tick   (tick)
`ifdef INPUT_DEBOUNCE_TOGGLE_EN
        ,
        .toggle (toggle)
`endif
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until a fresh tick is visible
    task automatic align_tick(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 16);
        check({tag, "_align"}, {31'd0, tick}, 32'd1);
    endtask

    task automatic drive_expect(input logic [W-1:0] d, input logic [W-1:0] er,
                                input logic [W-1:0] ef, input logic [W-1:0] ed);
        din = d;
        exp_q.push_back({er, ef, ed});
    endtask

    // Wait for the next pulse, check its latency and contents, then check it lasts one cycle
    task automatic expect_event(input string tag, input int exp_lat);
        int n = 0;
        logic [3*W-1:0] e;
        do begin
            step();
            n++;
        end while ((rise | fall) === '0 && n < 40);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_queue"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rise"}, rise, e[3*W-1:2*W]);
            check({tag, "_fall"}, fall, e[2*W-1:W]);
            check({tag, "_dout"}, dout, e[W-1:0]);
        end
        step();
        check({tag, "_pulse_end"}, rise | fall, 0);
    endtask

    // Pulse sanity on every enabled cycle: never both edges, never two cycles running
    logic [W-1:0] prev_rise = '0;
    logic [W-1:0] prev_fall = '0;
    always @(negedge clk) begin
        if (!rst) begin
            check("mon_rise_fall_overlap", rise & fall, 0);
            check("mon_back_to_back", (rise & prev_rise) | (fall & prev_fall), 0);
        end
        prev_rise = rise;
        prev_fall = fall;
    end

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        ena = 1'b1;
        din = 8'hFF;

        // Reset held with all inputs high: everything stays clear
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (dout !== '0 || rise !== '0 || fall !== '0 || tick !== 1'b0) bad++;
        end
        check("reset_outputs_zero", bad, 0);

        // Release: first tick after 4 edges, qualified after three consumed ticks
        rst = 1'b0;
        exp_q.push_back({8'hFF, 8'h00, 8'hFF});
        expect_event("reset_rise_all", 13);

        // Tick period
        align_tick("period");
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 16);
        check("tick_period", n, 4);
        step();
        check("tick_one_cycle", {31'd0, tick}, 0);

        // All channels fall together
        align_tick("all_fall");
        drive_expect(8'h00, 8'h00, 8'hFF, 8'h00);
        expect_event("all_fall", 13);

        // Bounce on bit 0: high for two ticks, low one cycle, then high for good
        align_tick("bounce");
        drive_expect(8'h01, 8'h01, 8'h00, 8'h01);
        n = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick === 1'b1) n++;
            if ((rise | fall) !== '0) bad++;
        end
        check("bounce_two_ticks", n, 2);
        din = 8'h00;
        step();
        if ((rise | fall) !== '0) bad++;
        din = 8'h01;
        check("bounce_no_early_pulse", bad, 0);
        check("bounce_dout_held", dout, 8'h00);
        expect_event("bounce_rise", 12);

        // Falling edge on bit 3
        align_tick("b3_up");
        drive_expect(8'h09, 8'h08, 8'h00, 8'h09);
        expect_event("b3_rise", 13);
        align_tick("b3_down");
        drive_expect(8'h01, 8'h00, 8'h08, 8'h01);
        expect_event("b3_fall", 13);

        // Enable dropped while bit 6 has one stable tick counted
        align_tick("ena");
        drive_expect(8'h41, 8'h40, 8'h00, 8'h41);
        for (int i = 0; i < 5; i++) step();
        ena = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick !== 1'b0 || rise !== '0 || fall !== '0 || dout !== 8'h01) bad++;
        end
        check("ena_low_frozen", bad, 0);
        ena = 1'b1;
        expect_event("ena_resume", 8);

        // Asynchronous reset while bit 5 has two stable ticks counted
        align_tick("arst");
        din = 8'h61;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if ((rise | fall) !== '0) bad++;
        end
        check("arst_no_early_pulse", bad, 0);
        check("arst_dout_before", dout, 8'h41);
        #1 rst = 1'b1;
        #1;
        check("arst_dout_clear", dout, 0);
        check("arst_tick_clear", {31'd0, tick}, 0);
        #1 rst = 1'b0;
        exp_q.push_back({8'h61, 8'h00, 8'h61});
        expect_event("arst_requalify", 13);

`ifdef INPUT_DEBOUNCE_TOGGLE_EN
        // Three press/release cycles on bit 1
        check("toggle_start", {31'd0, toggle[1]}, 0);
        for (int i = 0; i < 3; i++) begin
            align_tick("tg_press");
            drive_expect(8'h63, 8'h02, 8'h00, 8'h63);
            expect_event("tg_press", 13);
            check("toggle_after_rise", {31'd0, toggle[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            align_tick("tg_release");
            drive_expect(8'h61, 8'h00, 8'h02, 8'h61);
            expect_event("tg_release", 13);
            check("toggle_after_fall", {31'd0, toggle[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
